// File: rtl/fht_pkg.sv
// Shared types and helpers for the FHT frame scheduler: FSM states, bank
// constants and the load-order bit-reverse used with FHT_SCHED_BITREV_LOAD_EN.
package fht_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_RUN       = 3'd4,
        S_UNLOAD    = 3'd5,
        S_DRAIN     = 3'd6
    } fht_state_e;

    localparam int FHT_BANKS      = 4;
    localparam int FHT_A_BIT_DEF  = 8;
    localparam int FHT_N_DEF      = FHT_BANKS << FHT_A_BIT_DEF;
    localparam int FHT_WAIT_LIMIT = 4;
    localparam int FHT_OUT_DEPTH  = 2;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] fht_bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = 32'd0;
        for (int b = 0; b < 32; b++) begin
            if (b < w) begin
                r[5'(w - 1 - b)] = v[5'(b)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_out_skid.sv
// Two-entry FIFO between the result RAM read port and the output handshake.
// The head entry drives the output directly, so data holds while stalled.
module fht_out_skid
    import fht_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   occ_q;
    logic         pop_s;

    assign valid_o = (occ_q != 2'd0);
    assign pop_s   = valid_o & ready_i;
    assign data_o  = head_q;
    assign occ_o   = occ_q;

    // Entry storage and occupancy; the scheduler never pushes into a full buffer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({push_i, pop_s})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_q <= data_i;
                    end else begin
                        tail_q <= data_i;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= data_i;
                    end
                end
                default: begin
                    occ_q <= occ_q;
                end
            endcase
        end
    end

endmodule

// File: rtl/fht_frame_sched.sv
// Frame scheduler: loads N samples into 4 RAM banks, kicks the FHT, then
// unloads results in natural order. FHT_SCHED_BITREV_LOAD_EN bit-reverses load order.
module fht_frame_sched
    import fht_pkg::*;
#(
    parameter int A_BIT = FHT_A_BIT_DEF,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iDATA_VALID,
    output logic             oDATA_READY,
    input  logic             iDATA_LAST,
    output logic [A_BIT+1:0] oRAM_WR_ADDR,
    output logic [D_BIT-1:0] oRAM_WR_DATA,
    output logic             oRAM_WE,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic [A_BIT+1:0] oRAM_RD_ADDR,
    output logic             oRAM_RD_EN,
    input  logic [D_BIT-1:0] iRAM_RD_DATA,
    output logic [D_BIT-1:0] oDATA,
    output logic             oOUT_VALID,
    input  logic             iOUT_READY,
    output logic             oOUT_LAST,
    output logic             oBUSY,
    output logic             oERR
);

    localparam int IW = A_BIT + 2;

    fht_state_e      state_q;
    logic [IW-1:0]   cnt_q;
    logic [1:0]      wait_q;
    logic            err_q;
    logic            ready_q;
    logic            start_q;
    logic            inflight_q;
    logic            inflight_last_q;

    logic [IW-1:0]   wr_idx_s;
    logic            wr_fire_s;
    logic            rd_room_s;
    logic            rd_en_s;
    logic            pop_s;
    logic [1:0]      occ_s;
    logic            buf_valid_s;
    logic [D_BIT:0]  buf_data_s;

    // Load index and read-issue room: a read may go out only if its data
    // will find a free entry when it lands one cycle later.
    always_comb begin
`ifdef FHT_SCHED_BITREV_LOAD_EN
        wr_idx_s = IW'(fht_bitrev(32'(cnt_q), IW));
`else
        wr_idx_s = cnt_q;
`endif
        rd_room_s = (({1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s}) < 3'(FHT_OUT_DEPTH));
    end

    assign wr_fire_s    = iDATA_VALID & ready_q;
    assign pop_s        = buf_valid_s & iOUT_READY;
    assign rd_en_s      = (state_q == S_UNLOAD) & rd_room_s;

    assign oDATA_READY  = ready_q;
    assign oRAM_WE      = wr_fire_s;
    assign oRAM_WR_DATA = iDATA;
    assign oRAM_WR_ADDR = {wr_idx_s[1:0], wr_idx_s[IW-1:2]};
    assign oRAM_RD_EN   = rd_en_s;
    assign oRAM_RD_ADDR = {cnt_q[1:0], cnt_q[IW-1:2]};
    assign oFHT_START   = start_q;
    assign oBUSY        = (state_q != S_IDLE);
    assign oERR         = err_q;
    assign oOUT_VALID   = buf_valid_s;
    assign oDATA        = buf_data_s[D_BIT-1:0];
    assign oOUT_LAST    = buf_valid_s & buf_data_s[D_BIT];

    // Frame sequencing FSM; cnt_q counts load writes and later unload reads.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            wait_q          <= 2'd0;
            err_q           <= 1'b0;
            ready_q         <= 1'b0;
            start_q         <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= rd_en_s;
            inflight_last_q <= rd_en_s & (&cnt_q);
            case (state_q)
                S_IDLE: begin
                    if (iFHT_RDY) begin
                        state_q <= S_LOAD;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_LOAD: begin
                    if (wr_fire_s) begin
                        if (iDATA_LAST != (&cnt_q)) begin
                            err_q <= 1'b1;
                        end
                        cnt_q <= cnt_q + IW'(1);
                        if (&cnt_q) begin
                            state_q <= S_START;
                            ready_q <= 1'b0;
                            start_q <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    start_q <= 1'b0;
                    wait_q  <= 2'd0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!iFHT_RDY) begin
                        state_q <= S_RUN;
                    end else if (wait_q == 2'(FHT_WAIT_LIMIT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                S_RUN: begin
                    if (iFHT_RDY) begin
                        state_q <= S_UNLOAD;
                        cnt_q   <= '0;
                    end
                end
                S_UNLOAD: begin
                    if (rd_en_s) begin
                        cnt_q <= cnt_q + IW'(1);
                        if (&cnt_q) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((occ_s == 2'd0) && !inflight_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    fht_out_skid #(
        .W (D_BIT + 1)
    ) u_out_skid (
        .clk_i   (iCLK),
        .rst_ni  (iRESET),
        .push_i  (inflight_q),
        .data_i  ({inflight_last_q, iRAM_RD_DATA}),
        .ready_i (iOUT_READY),
        .valid_o (buf_valid_s),
        .data_o  (buf_data_s),
        .occ_o   (occ_s)
    );

endmodule

// File: tb/tb_fht_frame_sched.sv
// Directed-plus-random bench for fht_frame_sched with a behavioural RAM/FHT
// stand-in; honours FHT_SCHED_BITREV_LOAD_EN when computing expected addresses.
module tb_fht_frame_sched;

    localparam int AB = 8;
    localparam int DB = 16;
    localparam int N  = 1024;
    localparam int AW = 10;

    logic          iCLK = 1'b0;
    logic          iRESET;
    logic [DB-1:0] iDATA;
    logic          iDATA_VALID;
    logic          oDATA_READY;
    logic          iDATA_LAST;
    logic [AW-1:0] oRAM_WR_ADDR;
    logic [DB-1:0] oRAM_WR_DATA;
    logic          oRAM_WE;
    logic          oFHT_START;
    logic          iFHT_RDY;
    logic [AW-1:0] oRAM_RD_ADDR;
    logic          oRAM_RD_EN;
    logic [DB-1:0] iRAM_RD_DATA;
    logic [DB-1:0] oDATA;
    logic          oOUT_VALID;
    logic          iOUT_READY;
    logic          oOUT_LAST;
    logic          oBUSY;
    logic          oERR;

    always #5 iCLK = ~iCLK;

    fht_frame_sched #(.A_BIT(AB), .D_BIT(DB)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iDATA_VALID(iDATA_VALID),
        .oDATA_READY(oDATA_READY), .iDATA_LAST(iDATA_LAST),
        .oRAM_WR_ADDR(oRAM_WR_ADDR), .oRAM_WR_DATA(oRAM_WR_DATA), .oRAM_WE(oRAM_WE),
        .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY),
        .oRAM_RD_ADDR(oRAM_RD_ADDR), .oRAM_RD_EN(oRAM_RD_EN), .iRAM_RD_DATA(iRAM_RD_DATA),
        .oDATA(oDATA), .oOUT_VALID(oOUT_VALID), .iOUT_READY(iOUT_READY),
        .oOUT_LAST(oOUT_LAST), .oBUSY(oBUSY), .oERR(oERR)
    );

    logic [DB-1:0] ram     [0:N-1];
    logic [DB-1:0] mem_exp [0:N-1];
    logic [DB-1:0] smp     [0:N-1];
    logic [DB-1:0] rd_q;
    logic [15:0]   salt;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    int            err_mid;
    int            total  = 0;
    int            passed = 0;

    // The FHT is modelled as a per-address scramble applied on read-back.
    function automatic logic [DB-1:0] key(input logic [AW-1:0] a);
        return salt ^ {a[5:0], a};
    endfunction

    function automatic logic [AW-1:0] rev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) r[AW-1-b] = v[b];
        return r;
    endfunction

    function automatic logic [AW-1:0] load_addr(input int i);
        logic [AW-1:0] ix;
        ix = AW'(i);
`ifdef FHT_SCHED_BITREV_LOAD_EN
        ix = rev(ix);
`endif
        return {ix[1:0], ix[AW-1:2]};
    endfunction

    function automatic logic [AW-1:0] unload_addr(input int k);
        logic [AW-1:0] ix;
        ix = AW'(k);
        return {ix[1:0], ix[AW-1:2]};
    endfunction

    // Result RAM: write port from load, one-cycle-latency read port.
    always @(posedge iCLK) begin
        if (oRAM_WE) ram[oRAM_WR_ADDR] <= oRAM_WR_DATA;
        if (oRAM_RD_EN) rd_q <= ram[oRAM_RD_ADDR] ^ key(oRAM_RD_ADDR);
    end
    assign iRAM_RD_DATA = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load_frame(input int n_acc, input int extra_last, input bit rnd);
        int i, cyc, we_cnt, bad;
        for (int k = 0; k < N; k++) smp[k] = rnd ? DB'($urandom) : DB'(k);
        i = 0; cyc = 0; we_cnt = 0; bad = 0; err_mid = -1;
        while (i < n_acc && cyc < 4 * N) begin
            @(negedge iCLK);
            iDATA       = smp[i];
            iDATA_VALID = 1'b1;
            iDATA_LAST  = (i == N - 1) || (i == extra_last);
            #1;
            if (extra_last >= 0 && i == extra_last + 1 && err_mid < 0) err_mid = int'(oERR);
            if (oRAM_WE) we_cnt++;
            if (oDATA_READY) begin
                if (!oRAM_WE || oRAM_WR_ADDR !== load_addr(i) || oRAM_WR_DATA !== smp[i]) bad++;
                mem_exp[load_addr(i)] = smp[i];
                if (i == 0) addr0 = oRAM_WR_ADDR;
                if (i == 1) addr1 = oRAM_WR_ADDR;
                i++;
            end
            cyc++;
        end
        chk("load_writes", 32'(bad), 32'd0);
        chk("load_we_count", 32'(we_cnt), 32'(n_acc));
    endtask

    task automatic start_check();
        @(negedge iCLK);
        iDATA_VALID = 1'b0;
        iDATA_LAST  = 1'b0;
        #1;
        chk("start_pulse", 32'(oFHT_START), 32'd1);
        chk("ready_off_after_load", 32'(oDATA_READY), 32'd0);
    endtask

    task automatic run_and_unload(input int run_cyc, input bit rnd);
        int bad, got, cyc, first_v, last_x, rd_cnt, extra, lasts, stab;
        logic [AW-1:0] a;
        logic          held, held_l;
        logic [DB-1:0] held_d;
        iFHT_RDY = 1'b0;
        bad = 0;
        for (int k = 0; k < run_cyc; k++) begin
            @(negedge iCLK); #1;
            if (!oBUSY || oRAM_RD_EN || oOUT_VALID || oFHT_START) bad++;
        end
        chk("run_hold", 32'(bad), 32'd0);
        @(negedge iCLK);
        iFHT_RDY   = 1'b1;
        iOUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        got = 0; cyc = 0; first_v = -1; last_x = -1; rd_cnt = 0;
        bad = 0; lasts = 0; stab = 0; held = 1'b0; held_l = 1'b0; held_d = '0;
        while (got < N && cyc < 8 * N) begin
            if (oRAM_RD_EN) rd_cnt++;
            if (held && (!oOUT_VALID || oDATA !== held_d || oOUT_LAST !== held_l)) stab++;
            held   = oOUT_VALID && !iOUT_READY;
            held_d = oDATA;
            held_l = oOUT_LAST;
            if (oOUT_VALID) begin
                if (first_v < 0) first_v = cyc;
                if (iOUT_READY) begin
                    a = unload_addr(got);
                    if (oDATA !== (mem_exp[a] ^ key(a))) bad++;
                    if (oOUT_LAST) lasts++;
                    if (oOUT_LAST !== (got == N - 1)) bad++;
                    last_x = cyc;
                    got++;
                end
            end
            @(negedge iCLK);
            iOUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            cyc++;
        end
        iFHT_RDY = 1'b0;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            if (oOUT_VALID) extra++;
            if (oRAM_RD_EN) rd_cnt++;
            @(negedge iCLK);
            iOUT_READY = 1'b1;
            #1;
        end
        chk("unload_count", 32'(got), 32'(N));
        chk("unload_data", 32'(bad), 32'd0);
        chk("unload_last_count", 32'(lasts), 32'd1);
        chk("unload_stable", 32'(stab), 32'd0);
        chk("unload_reads", 32'(rd_cnt), 32'(N));
        chk("unload_no_extra", 32'(extra), 32'd0);
        chk("first_valid_latency", 32'(first_v - 1), 32'd2);
        chk("idle_after_drain", 32'(oBUSY), 32'd0);
        if (!rnd) chk("full_throughput", 32'(last_x - first_v), 32'(N - 1));
    endtask

    initial begin
        int idle_at, extra_st;
        logic [AW-1:0] exp_a1;
        salt        = 16'($urandom);
        iRESET      = 1'b0;
        iDATA       = '0;
        iDATA_VALID = 1'b0;
        iDATA_LAST  = 1'b0;
        iFHT_RDY    = 1'b0;
        iOUT_READY  = 1'b0;
        repeat (3) @(negedge iCLK);
        #1;
        chk("reset_flags", 32'({oDATA_READY, oRAM_WE, oFHT_START, oRAM_RD_EN,
                                oOUT_VALID, oOUT_LAST, oBUSY, oERR}), 32'd0);
        chk("reset_addrs", 32'({oRAM_WR_ADDR, oRAM_RD_ADDR}), 32'd0);
        chk("reset_data", 32'(oDATA), 32'd0);
        iRESET = 1'b1;
        repeat (3) @(negedge iCLK);
        #1;
        chk("idle_waits_for_rdy", 32'(oBUSY), 32'd0);
        iFHT_RDY = 1'b1;

        // Frame A: value = i, then FHT never goes busy.
        load_frame(N, -1, 1'b0);
`ifdef FHT_SCHED_BITREV_LOAD_EN
        exp_a1 = 10'h080;
`else
        exp_a1 = 10'h100;
`endif
        chk("addr_of_sample1", 32'(addr1), 32'(exp_a1));
        start_check();
        idle_at = -1; extra_st = 0;
        for (int k = 1; k <= 8 && idle_at < 0; k++) begin
            @(negedge iCLK); #1;
            if (oFHT_START) extra_st++;
            if (!oBUSY) begin
                idle_at = k;
                chk("timeout_err", 32'(oERR), 32'd1);
            end
        end
        chk("timeout_cycles", 32'(idle_at), 32'd5);
        chk("single_start", 32'(extra_st), 32'd0);
        @(negedge iCLK); #1;
        chk("err_clear_on_load", 32'(oERR), 32'd0);
        chk("ready_in_load", 32'(oDATA_READY), 32'd1);

        // Frame B: early LAST at 500, long RUN, random output back-pressure.
        load_frame(N, 500, 1'b1);
        chk("err_early_last", 32'(err_mid), 32'd1);
        start_check();
        chk("err_sticky", 32'(oERR), 32'd1);
        run_and_unload(2600, 1'b1);

        // Frame C: reset in the middle of loading.
        iFHT_RDY = 1'b1;
        load_frame(300, -1, 1'b1);
        @(negedge iCLK);
        iRESET = 1'b0;
        iDATA_VALID = 1'b1;
        @(negedge iCLK);
        iRESET = 1'b1;
        #1;
        chk("midload_reset_flags", 32'({oDATA_READY, oRAM_WE, oFHT_START, oRAM_RD_EN,
                                        oOUT_VALID, oOUT_LAST, oBUSY, oERR}), 32'd0);
        chk("midload_reset_addrs", 32'({oRAM_WR_ADDR, oRAM_RD_ADDR}), 32'd0);
        chk("midload_reset_data", 32'(oDATA), 32'd0);

        // Frame D: clean frame after reset, output always ready.
        load_frame(N, -1, 1'b1);
        chk("addr_after_reset", 32'(addr0), 32'd0);
        start_check();
        run_and_unload(20, 1'b0);
        chk("err_clean_frame", 32'(oERR), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
